// File: rtl/sd_emmc_raid0_pkg.sv
// Shared encodings for the two-device eMMC RAID0 command scheduler:
// command indices, response types, interrupt bit positions, FSM states.
package sd_emmc_raid0_pkg;

    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_READ_MULTI   = 6'd18;
    localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;
    localparam logic [5:0] CMD_WRITE_MULTI  = 6'd25;

    localparam logic [1:0] RESP_NONE  = 2'b00;
    localparam logic [1:0] RESP_R2    = 2'b01;
    localparam logic [1:0] RESP_SHORT = 2'b10;
    localparam logic [1:0] RESP_R1B   = 2'b11;

    localparam int IS_CC    = 0;
    localparam int IS_EI    = 1;
    localparam int IS_CTE   = 2;
    localparam int IS_CCRCE = 3;
    localparam int IS_CIE   = 4;
    localparam int IS_BTE   = 5;
    localparam int IS_MISM  = 6;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_RESP = 3'd2;
    localparam logic [2:0] ST_BUSY_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/sd_emmc_raid0_arg_map.sv
// Channel selection and per-device LBA remap for RAID0 striping.
// Even LBAs live on dev0, odd LBAs on dev1, each device sees LBA/2.
module sd_emmc_raid0_arg_map
    import sd_emmc_raid0_pkg::*;
(
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic [1:0]  active,
    output logic [31:0] arg0,
    output logic [31:0] arg1
);

    logic        single;
    logic        multi;
    logic [32:0] inc;
    logic [31:0] half;
    logic [31:0] half_up;

    assign single  = (cmd_index == CMD_READ_SINGLE) ||
                     (cmd_index == CMD_WRITE_SINGLE);
    assign multi   = (cmd_index == CMD_READ_MULTI) ||
                     (cmd_index == CMD_WRITE_MULTI);
    assign inc     = {1'b0, argument} + 33'd1;
    assign half    = argument >> 1;
    assign half_up = inc[32:1];

    always_comb begin
        active = 2'b11;
        arg0   = argument;
        arg1   = argument;
        unique case (1'b1)
            single: begin
                active = argument[0] ? 2'b10 : 2'b01;
                arg0   = half;
                arg1   = half;
            end
            multi: begin
                arg0 = argument[0] ? half_up : half;
                arg1 = argument[0] ? half : half_up;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sd_emmc_raid0_cmd_sched.sv
// Issues one host command to one or both eMMC CMD channels, waits for
// the responses, and merges status and response into a single result.
module sd_emmc_raid0_cmd_sched
    import sd_emmc_raid0_pkg::*;
#(
    parameter int unsigned TO_SHORT = 120,
    parameter int unsigned TO_LONG  = 250,
    parameter int unsigned TO_NONE  = 64,
    parameter int unsigned TO_BUSY  = 2 ** 20
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  argument_i,
    input  logic [1:0]   resp_type_i,
    input  logic         crc_chk_i,
    input  logic         idx_chk_i,
    input  logic         int_clr_i,
    output logic         start0_o,
    output logic         start1_o,
    output logic [39:0]  cmd0_o,
    output logic [39:0]  cmd1_o,
    input  logic         finish0_i,
    input  logic         finish1_i,
    input  logic         crc0_ok_i,
    input  logic         crc1_ok_i,
    input  logic         idx0_ok_i,
    input  logic         idx1_ok_i,
    input  logic [119:0] resp0_i,
    input  logic [119:0] resp1_i,
    input  logic         busy0_i,
    input  logic         busy1_i,
    output logic [127:0] response_o,
    output logic [6:0]   int_status_o,
    output logic [1:0]   active_o,
    output logic         busy_o,
    output logic         go_idle_o
);

    // Watchdog counts from 0 in the first cycle of a state, so a limit
    // of N fires in the Nth cycle after the ISSUE cycle.
    localparam logic [20:0] LIM_SHORT = 21'(TO_SHORT - 1);
    localparam logic [20:0] LIM_LONG  = 21'(TO_LONG - 1);
    localparam logic [20:0] LIM_NONE  = 21'(TO_NONE - 1);
    localparam logic [20:0] LIM_BUSY  = 21'(TO_BUSY - 1);

    logic [2:0]   state;
    logic [2:0]   state_nx;
    logic [20:0]  wd;
    logic [20:0]  lim;
    logic [1:0]   active;
    logic [1:0]   got;
    logic [1:0]   got_nx;
    logic [1:0]   fin;
    logic [1:0]   resp_type;
    logic [119:0] r0;
    logic [119:0] r1;
    logic [119:0] sel;
    logic [127:0] merged;
    logic [6:0]   ist;
    logic         all_got;
    logic         busy_any;
    logic         to_hit;
    logic         bto_hit;
    logic         accept;
    logic         mism;
    logic         err;
    logic [1:0]   map_act;
    logic [31:0]  map_a0;
    logic [31:0]  map_a1;

    sd_emmc_raid0_arg_map u_arg_map (
        .cmd_index (cmd_index_i),
        .argument  (argument_i),
        .active    (map_act),
        .arg0      (map_a0),
        .arg1      (map_a1)
    );

    assign accept   = (state == ST_IDLE) && start_i && !abort_i;
    assign fin      = {finish1_i, finish0_i} & active;
    assign got_nx   = got | fin;
    assign all_got  = (got_nx == active);
    assign busy_any = |({busy1_i, busy0_i} & active);
    assign to_hit   = (state == ST_WAIT_RESP) && !all_got && (wd >= lim);
    assign bto_hit  = (state == ST_BUSY_WAIT) && busy_any && (wd >= LIM_BUSY);

    always_comb begin
        unique case (resp_type)
            RESP_NONE: lim = LIM_NONE;
            RESP_R2:   lim = LIM_LONG;
            default:   lim = LIM_SHORT;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:      if (start_i) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (all_got)
                    state_nx = (resp_type == RESP_R1B) ? ST_BUSY_WAIT : ST_DONE;
                else if (to_hit)
                    state_nx = ST_DONE;
            end
            ST_BUSY_WAIT: if (!busy_any || bto_hit) state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
        if (abort_i) state_nx = ST_IDLE;
    end

    assign sel  = active[0] ? r0 : r1;
    assign mism = (got == active) && resp_type[1] && (active == 2'b11) &&
                  (r0[119:88] != r1[119:88]);
    assign err  = ist[IS_BTE] | ist[IS_CIE] | ist[IS_CCRCE] |
                  ist[IS_CTE] | mism;

    always_comb begin
        merged = '0;
        unique case (resp_type)
            RESP_R2:              merged = {8'h00, sel};
            RESP_SHORT, RESP_R1B: merged[31:0] = sel[119:88];
            default: ;
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wd         <= '0;
            active     <= '0;
            got        <= '0;
            resp_type  <= '0;
            r0         <= '0;
            r1         <= '0;
            ist        <= '0;
            cmd0_o     <= '0;
            cmd1_o     <= '0;
            response_o <= '0;
        end else begin
            state <= state_nx;
            wd    <= (state_nx != state) ? '0 : wd + 21'd1;
            if (state == ST_IDLE && int_clr_i) ist <= '0;
            if (accept) begin
                active    <= map_act;
                resp_type <= resp_type_i;
                cmd0_o    <= {2'b01, cmd_index_i, map_a0};
                cmd1_o    <= {2'b01, cmd_index_i, map_a1};
                got       <= '0;
                ist       <= '0;
            end
            if (state == ST_WAIT_RESP && !abort_i) begin
                got <= got_nx;
                if (fin[0]) begin
                    r0 <= resp0_i;
                    if (crc_chk_i && !crc0_ok_i) ist[IS_CCRCE] <= 1'b1;
                    if (idx_chk_i && !idx0_ok_i) ist[IS_CIE] <= 1'b1;
                end
                if (fin[1]) begin
                    r1 <= resp1_i;
                    if (crc_chk_i && !crc1_ok_i) ist[IS_CCRCE] <= 1'b1;
                    if (idx_chk_i && !idx1_ok_i) ist[IS_CIE] <= 1'b1;
                end
                if (to_hit) ist[IS_CTE] <= 1'b1;
            end
            if (bto_hit && !abort_i) ist[IS_BTE] <= 1'b1;
            if (state == ST_DONE && !abort_i) begin
                ist[IS_CC]   <= 1'b1;
                ist[IS_EI]   <= err;
                ist[IS_MISM] <= ist[IS_MISM] | mism;
                response_o   <= (got == active) ? merged : '0;
            end
        end
    end

    assign start0_o     = (state == ST_ISSUE) && active[0];
    assign start1_o     = (state == ST_ISSUE) && active[1];
    assign active_o     = active;
    assign busy_o       = (state != ST_IDLE);
    assign go_idle_o    = abort_i || to_hit || bto_hit;
    assign int_status_o = (state == ST_IDLE && !int_clr_i) ? ist : '0;

endmodule

// File: tb/tb_sd_emmc_raid0_cmd_sched.sv
// Directed bench for the RAID0 command scheduler with a result scoreboard.
module tb_sd_emmc_raid0_cmd_sched;

    typedef struct packed {
        logic [6:0]   ist;
        logic [127:0] rsp;
        logic [1:0]   act;
    } exp_t;

    logic         sd_clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         abort_i;
    logic [5:0]   cmd_index_i;
    logic [31:0]  argument_i;
    logic [1:0]   resp_type_i;
    logic         crc_chk_i;
    logic         idx_chk_i;
    logic         int_clr_i;
    logic         start0_o;
    logic         start1_o;
    logic [39:0]  cmd0_o;
    logic [39:0]  cmd1_o;
    logic         finish0_i;
    logic         finish1_i;
    logic         crc0_ok_i;
    logic         crc1_ok_i;
    logic         idx0_ok_i;
    logic         idx1_ok_i;
    logic [119:0] resp0_i;
    logic [119:0] resp1_i;
    logic         busy0_i;
    logic         busy1_i;
    logic [127:0] response_o;
    logic [6:0]   int_status_o;
    logic [1:0]   active_o;
    logic         busy_o;
    logic         go_idle_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    sd_emmc_raid0_cmd_sched dut (
        .sd_clk       (sd_clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cmd_index_i  (cmd_index_i),
        .argument_i   (argument_i),
        .resp_type_i  (resp_type_i),
        .crc_chk_i    (crc_chk_i),
        .idx_chk_i    (idx_chk_i),
        .int_clr_i    (int_clr_i),
        .start0_o     (start0_o),
        .start1_o     (start1_o),
        .cmd0_o       (cmd0_o),
        .cmd1_o       (cmd1_o),
        .finish0_i    (finish0_i),
        .finish1_i    (finish1_i),
        .crc0_ok_i    (crc0_ok_i),
        .crc1_ok_i    (crc1_ok_i),
        .idx0_ok_i    (idx0_ok_i),
        .idx1_ok_i    (idx1_ok_i),
        .resp0_i      (resp0_i),
        .resp1_i      (resp1_i),
        .busy0_i      (busy0_i),
        .busy1_i      (busy1_i),
        .response_o   (response_o),
        .int_status_o (int_status_o),
        .active_o     (active_o),
        .busy_o       (busy_o),
        .go_idle_o    (go_idle_o)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sd_clk);
    endtask

    task automatic push_exp(input logic [6:0] ist, input logic [127:0] rsp,
                            input logic [1:0] act);
        exp_t e;
        e.ist = ist;
        e.rsp = rsp;
        e.act = act;
        sbq.push_back(e);
    endtask

    // Leaves the bench at the negedge of the ISSUE cycle (cycle 0).
    task automatic issue(input string tag, input logic [5:0] idx,
                         input logic [31:0] arg, input logic [1:0] rt,
                         input logic s0, input logic s1);
        cmd_index_i = idx;
        argument_i  = arg;
        resp_type_i = rt;
        start_i     = 1'b1;
        @(negedge sd_clk);
        start_i = 1'b0;
        chk({tag, "_start0"}, 128'(start0_o), 128'(s0));
        chk({tag, "_start1"}, 128'(start1_o), 128'(s1));
    endtask

    task automatic pulse_fin(input logic f0, input logic f1);
        finish0_i = f0;
        finish1_i = f1;
        @(negedge sd_clk);
        finish0_i = 1'b0;
        finish1_i = 1'b0;
        crc0_ok_i = 1'b1;
        crc1_ok_i = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n = 0;
        while (busy_o && n < 2000) begin
            @(negedge sd_clk);
            n++;
        end
        chk({tag, "_done"}, 128'(busy_o), 128'(1'b0));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_ist"}, 128'(int_status_o), 128'(e.ist));
            chk({tag, "_rsp"}, response_o, e.rsp);
            chk({tag, "_act"}, 128'(active_o), 128'(e.act));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        cmd_index_i = '0;
        argument_i = '0;
        resp_type_i = '0;
        crc_chk_i = 1'b1;
        idx_chk_i = 1'b1;
        int_clr_i = 1'b0;
        finish0_i = 1'b0;
        finish1_i = 1'b0;
        crc0_ok_i = 1'b1;
        crc1_ok_i = 1'b1;
        idx0_ok_i = 1'b1;
        idx1_ok_i = 1'b1;
        resp0_i = '0;
        resp1_i = '0;
        busy0_i = 1'b0;
        busy1_i = 1'b0;
        cyc(3);
        chk("rst_busy", 128'(busy_o), 128'(1'b0));
        chk("rst_act", 128'(active_o), 128'(2'b00));
        chk("rst_ist", 128'(int_status_o), 128'(7'h00));
        chk("rst_rsp", response_o, 128'h0);
        chk("rst_cmd0", 128'(cmd0_o), 128'(40'h0));
        chk("rst_goidle", 128'(go_idle_o), 128'(1'b0));
        rst_n = 1'b1;
        cyc(1);

        // CMD0 broadcast, no response
        push_exp(7'h01, 128'h0, 2'b11);
        issue("cmd0", 6'd0, 32'h0, 2'b00, 1'b1, 1'b1);
        chk("cmd0_c0", 128'(cmd0_o), 128'(40'h40_0000_0000));
        chk("cmd0_c1", 128'(cmd1_o), 128'(40'h40_0000_0000));
        cyc(1);
        chk("cmd0_pulse1", 128'(start0_o), 128'(1'b0));
        cyc(9);
        pulse_fin(1'b1, 1'b1);
        wait_done("cmd0");

        // CMD17 odd LBA -> dev1 only, CRC error
        resp1_i = {32'h1234_5678, 88'h0};
        push_exp(7'h0B, 128'h1234_5678, 2'b10);
        issue("cmd17", 6'd17, 32'h0000_0105, 2'b10, 1'b0, 1'b1);
        chk("cmd17_c1", 128'(cmd1_o), 128'(40'h51_0000_0082));
        cyc(5);
        crc1_ok_i = 1'b0;
        pulse_fin(1'b0, 1'b1);
        wait_done("cmd17");
        int_clr_i = 1'b1;
        #1;
        chk("clr_same", 128'(int_status_o), 128'(7'h00));
        @(negedge sd_clk);
        int_clr_i = 1'b0;
        chk("clr_after", 128'(int_status_o), 128'(7'h00));

        // CMD18 split, late finish1, stray start ignored
        resp0_i = {32'hAAAA_0001, 88'h0};
        resp1_i = {32'hAAAA_0001, 88'h5};
        push_exp(7'h01, 128'hAAAA_0001, 2'b11);
        issue("cmd18", 6'd18, 32'h0000_0007, 2'b10, 1'b1, 1'b1);
        chk("cmd18_c0", 128'(cmd0_o), 128'(40'h52_0000_0004));
        chk("cmd18_c1", 128'(cmd1_o), 128'(40'h52_0000_0003));
        cyc(5);
        pulse_fin(1'b1, 1'b0);
        cmd_index_i = 6'd17;
        argument_i  = 32'h0000_0105;
        start_i     = 1'b1;
        @(negedge sd_clk);
        start_i = 1'b0;
        chk("ign_start_c0", 128'(cmd0_o), 128'(40'h52_0000_0004));
        chk("ign_start_act", 128'(active_o), 128'(2'b11));
        cyc(32);
        chk("cmd18_wait39", 128'(busy_o), 128'(1'b1));
        cyc(1);
        pulse_fin(1'b0, 1'b1);
        wait_done("cmd18");

        // CMD13 responses disagree, both finish together
        resp0_i = {32'h0000_0900, 88'h0};
        resp1_i = {32'h0000_0B00, 88'h0};
        push_exp(7'h43, 128'h0000_0900, 2'b11);
        issue("cmd13", 6'd13, 32'h0001_0000, 2'b10, 1'b1, 1'b1);
        cyc(8);
        pulse_fin(1'b1, 1'b1);
        wait_done("cmd13");

        // CMD7 timeout: dev1 never answers
        push_exp(7'h07, 128'h0, 2'b11);
        issue("cmd7to", 6'd7, 32'h0001_0000, 2'b10, 1'b1, 1'b1);
        cyc(10);
        pulse_fin(1'b1, 1'b0);
        seen = -1;
        for (int c = 11; c < 300; c++) begin
            if (go_idle_o) begin
                seen = c;
                break;
            end
            @(negedge sd_clk);
        end
        chk("cmd7to_cycle", 128'(seen), 128'(120));
        wait_done("cmd7to");

        // Finish lands on the expiry cycle: no CTE
        resp1_i = resp0_i;
        push_exp(7'h01, 128'h0000_0900, 2'b11);
        issue("cmd7edge", 6'd7, 32'h0001_0000, 2'b10, 1'b1, 1'b1);
        cyc(10);
        pulse_fin(1'b1, 1'b0);
        cyc(109);
        finish1_i = 1'b1;
        #1;
        chk("cmd7edge_goidle", 128'(go_idle_o), 128'(1'b0));
        @(negedge sd_clk);
        finish1_i = 1'b0;
        wait_done("cmd7edge");

        // CMD24 even LBA -> dev0; stray bad finish1 ignored
        push_exp(7'h01, 128'h0000_0900, 2'b01);
        issue("cmd24", 6'd24, 32'h0000_0010, 2'b10, 1'b1, 1'b0);
        chk("cmd24_c0", 128'(cmd0_o), 128'(40'h58_0000_0008));
        cyc(4);
        crc1_ok_i = 1'b0;
        pulse_fin(1'b0, 1'b1);
        chk("cmd24_still", 128'(busy_o), 128'(1'b1));
        cyc(4);
        pulse_fin(1'b1, 1'b0);
        wait_done("cmd24");

        // CMD2 long response from dev0
        resp0_i = 120'hA1_B2C3_D4E5_F607_1829_3A4B_5C6D_7E8F;
        resp1_i = 120'h11_2233_4455_6677_8899_AABB_CCDD_EEFF;
        push_exp(7'h01, {8'h00, 120'hA1_B2C3_D4E5_F607_1829_3A4B_5C6D_7E8F},
                 2'b11);
        issue("cmd2", 6'd2, 32'h0, 2'b01, 1'b1, 1'b1);
        cyc(3);
        pulse_fin(1'b1, 1'b1);
        wait_done("cmd2");

        // CMD6 R1b, dev1 busy for 500 cycles
        resp0_i = {32'h0000_0900, 88'h0};
        resp1_i = resp0_i;
        push_exp(7'h01, 128'h0000_0900, 2'b11);
        issue("cmd6", 6'd6, 32'h03B7_0100, 2'b11, 1'b1, 1'b1);
        cyc(5);
        busy1_i = 1'b1;
        pulse_fin(1'b1, 1'b1);
        cyc(499);
        chk("cmd6_busy500", 128'(busy_o), 128'(1'b1));
        busy1_i = 1'b0;
        wait_done("cmd6");

        // CMD6 R1b aborted during busy
        issue("cmd6ab", 6'd6, 32'h03B7_0100, 2'b11, 1'b1, 1'b1);
        cyc(5);
        busy1_i = 1'b1;
        pulse_fin(1'b1, 1'b1);
        cyc(20);
        abort_i = 1'b1;
        #1;
        chk("cmd6ab_goidle", 128'(go_idle_o), 128'(1'b1));
        @(negedge sd_clk);
        abort_i = 1'b0;
        busy1_i = 1'b0;
        chk("cmd6ab_idle", 128'(busy_o), 128'(1'b0));
        chk("cmd6ab_ist", 128'(int_status_o), 128'(7'h00));

        // abort beats start in IDLE
        cmd_index_i = 6'd0;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge sd_clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_vs_start", 128'(busy_o), 128'(1'b0));

        // asynchronous reset mid-command
        issue("rstmid", 6'd0, 32'h0, 2'b00, 1'b1, 1'b1);
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 128'(busy_o), 128'(1'b0));
        chk("rstmid_act", 128'(active_o), 128'(2'b00));
        chk("rstmid_rsp", response_o, 128'h0);
        @(negedge sd_clk);
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
